// File: rtl/seq_divider_core.sv
// seq_divider_core: sequential radix-2 restoring divider.
// Produces one quotient bit per clock. done is a one-cycle pulse, and
// quotient/remainder/div_by_zero are valid and held from that cycle on.
// Optional macro DIV_SIGNED_EN: two's complement operands. Magnitudes are
// divided unsigned and the sign fix-up is applied as the results are loaded.
// Without the macro the core is purely unsigned and carries no sign logic.
module seq_divider_core #(
    parameter int Word_Length = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [Word_Length-1:0] dividend,
    input  logic [Word_Length-1:0] divisor,
    output logic                   busy,
    output logic                   done,
    output logic [Word_Length-1:0] quotient,
    output logic [Word_Length-1:0] remainder,
    output logic                   div_by_zero
);

    localparam int CW = (Word_Length > 2) ? $clog2(Word_Length) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(Word_Length - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [Word_Length-1:0] q_reg;
    logic [Word_Length-1:0] d_reg;
    logic [Word_Length-1:0] r_reg;

    logic [Word_Length:0]   t_val;
    logic                   t_ge_d;
    logic [Word_Length-1:0] q_next;
    logic [Word_Length-1:0] r_next;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Two's complement magnitude; the most-negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [Word_Length-1:0] magnitude(input logic [Word_Length-1:0] v);
        return v[Word_Length-1] ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's complement negation used for the sign fix-up.
    function automatic logic [Word_Length-1:0] apply_sign(input logic [Word_Length-1:0] v,
                                                          input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder (one extra MSB) and subtract the divisor if it fits. The
    // subtraction is done in Word_Length bits because the true difference
    // is always below the divisor.
    always_comb begin
        t_val  = {r_reg, q_reg[Word_Length-1]};
        t_ge_d = (t_val >= {1'b0, d_reg});
        r_next = t_ge_d ? (t_val[Word_Length-1:0] - d_reg) : t_val[Word_Length-1:0];
        q_next = {q_reg[Word_Length-2:0], t_ge_d};
    end

    // Control FSM with registered outputs; results load on entry to DONE so
    // they are valid in the same cycle as the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        count       <= '0;
                        r_reg       <= '0;
                        div_by_zero <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                        q_reg       <= magnitude(dividend);
                        d_reg       <= magnitude(divisor);
                        neg_q       <= dividend[Word_Length-1] ^ divisor[Word_Length-1];
                        neg_r       <= dividend[Word_Length-1];
`else
                        q_reg       <= dividend;
                        d_reg       <= divisor;
`endif
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to DONE.
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        state <= DONE;
                        done  <= 1'b1;
`ifdef DIV_SIGNED_EN
                        quotient  <= apply_sign(q_next, neg_q);
                        remainder <= apply_sign(r_next, neg_r);
`else
                        quotient  <= q_next;
                        remainder <= r_next;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_core.sv
// Testbench for seq_divider_core (Word_Length = 16). Reference results come
// from plain integer division; DIV_SIGNED_EN selects the signed model.
module tb_seq_divider_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    always #5 clk = ~clk;

    seq_divider_core #(.Word_Length(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference division from the arithmetic definition.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        dz = (b == '0);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            begin : signed_div
                int sa, sb, sq, sr;
                sa = $signed(a);
                sb = $signed(b);
                sq = sa / sb;
                sr = sa % sb;
                q  = sq[W-1:0];
                r  = sr[W-1:0];
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Starts one operation in the current (IDLE) cycle, checks busy/latency
    // and results, then spends the following IDLE cycle checking the pulse
    // ends. If poke matches a cycle number, start is raised with junk operands
    // in that busy cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           cyc;
        int           lat;
        model(a, b, eq, er, edz);
        lat      = (b == '0) ? 1 : W + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        cyc      = 1;
        check_bit("busy_c1", busy, 1'b1);
        check_bit("dz_c1", div_by_zero, edz);
        if (b != '0) check("hold_q_c1", quotient, prev_q);
        while (done !== 1'b1 && cyc < W + 6) begin
            check_bit("busy_calc", busy, 1'b1);
            start = (cyc == poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", W'(cyc), W'(lat));
        check_bit("done", done, 1'b1);
        check_bit("busy_done", busy, 1'b1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check_bit("div_by_zero", div_by_zero, edz);
        prev_q = eq;
        prev_r = er;
        @(posedge clk); #1;
        check_bit("done_drop", done, 1'b0);
        check_bit("busy_drop", busy, 1'b0);
        check("hold_q_idle", quotient, eq);
        check("hold_r_idle", remainder, er);
    endtask

    initial begin
        int done_seen;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check("rst_q", quotient, 16'h0000);
        check("rst_r", remainder, 16'h0000);
        check_bit("rst_dz", div_by_zero, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic division
        run_op(16'd100, 16'd7, -1);
        check("q_100_7", quotient, 16'd14);
        check("r_100_7", remainder, 16'd2);

        // Back-to-back: second start in the first IDLE cycle
        run_op(16'hFFFF, 16'h0001, -1);
        check("q_ffff_1", quotient, 16'hFFFF);
        check("r_ffff_1", remainder, 16'h0000);
        run_op(16'h0000, 16'h0003, -1);
        check("q_0_3", quotient, 16'h0000);
        check("r_0_3", remainder, 16'h0000);

        // Divide by zero, then a valid division clears the flag
        run_op(16'd5, 16'd0, -1);
        check("q_5_0", quotient, 16'hFFFF);
        check("r_5_0", remainder, 16'd5);
        check_bit("dz_5_0", div_by_zero, 1'b1);
        run_op(16'd100, 16'd7, -1);
        check_bit("dz_cleared", div_by_zero, 1'b0);

        // Start while busy is ignored
        run_op(16'd100, 16'd7, 5);
        check("q_poke", quotient, 16'd14);
        run_op(16'd200, 16'd9, W);

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'h0002, -1);
        check("q_m7_2", quotient, 16'hFFFD);
        check("r_m7_2", remainder, 16'hFFFF);
        run_op(16'h0007, 16'hFFFE, -1);
        check("q_7_m2", quotient, 16'hFFFD);
        check("r_7_m2", remainder, 16'h0001);
        run_op(16'h8000, 16'hFFFF, -1);
        check("q_min_m1", quotient, 16'h8000);
        check("r_min_m1", remainder, 16'h0000);
        check_bit("dz_min_m1", div_by_zero, 1'b0);
`else
        run_op(16'h8000, 16'h0003, -1);
        check("q_8000_3", quotient, 16'h2AAA);
        check("r_8000_3", remainder, 16'h0002);
`endif

        // Reset in the middle of CALC aborts without a done pulse
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check("abort_q", quotient, 16'h0000);
        check("abort_r", remainder, 16'h0000);
        check_bit("abort_dz", div_by_zero, 1'b0);
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (done === 1'b1) done_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", W'(done_seen), 16'd0);
        check_bit("abort_idle_busy", busy, 1'b0);
        prev_q = '0;
        prev_r = '0;
        run_op(16'd9, 16'd3, -1);
        check("q_9_3", quotient, 16'd3);
        check("r_9_3", remainder, 16'd0);

        // Randomised operands, including zero and small divisors
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            if (i % 7 == 0)      b = '0;
            else if (i % 3 == 0) b = W'($urandom_range(1, 15));
            else                 b = W'($urandom);
            run_op(a, b, (i % 5 == 0) ? int'($urandom_range(1, W)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
